// File: rtl/fmdll_pkg.sv
// Shared types and defaults for the DLL frequency lock monitor.
package fmdll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam int CNT_W        = 6;
  localparam int LOCK_CNT_DEF = 4;
  localparam int TOL_DEF      = 1;
  localparam int TIMEOUT_DEF  = 255;

endpackage

// File: rtl/fmdll_edge_sync.sv
// Two-flop synchronizer for the reference clock plus a registered rising-edge
// detector; rise pulses for one cycle, three cycles after the raw edge.
module fmdll_edge_sync (
  input  logic clk_out,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/fmdll_lock_mon.sv
// Counts clk_out cycles across M reference periods, compares the count with N
// and asserts locked after LOCK_CNT consecutive in-tolerance windows.
module fmdll_lock_mon
  import fmdll_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             clk_ext,
  input  logic [1:0]       M,
  input  logic [3:0]       N,
  output logic             locked,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             err,
  output logic             lost_ref,
  output logic             cfg_err
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  state_t           state;
  logic             ref_rise;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_inc;
  logic [1:0]       ref_cnt;
  logic [1:0]       ref_cnt_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_inc;
  logic [1:0]       m_q;
  logic [3:0]       n_q;
  logic             cfg_chg;
  logic             close_win;
  logic             timeout_hit;
  logic signed [6:0] diff;
  logic [6:0]       diff_abs;
  logic             pass;

  fmdll_edge_sync u_sync (
    .clk_out (clk_out),
    .rst     (rst),
    .d       (clk_ext),
    .rise    (ref_rise)
  );

  assign cfg_err     = (M == 2'd0) || (N == 4'd0);
  assign cfg_chg     = (M != m_q) || (N != n_q);
  assign ref_cnt_nxt = ref_cnt + 2'd1;
  assign close_win   = ref_rise && (ref_cnt_nxt == m_q);
  // A reference edge in the same cycle always wins over the timeout.
  assign timeout_hit = !ref_rise && !lost_ref && (to_cnt == TO_W'(TIMEOUT - 1));
  assign win_inc     = (win_cnt == '1) ? win_cnt : win_cnt + 1'b1;
  assign run_inc     = (run_cnt == RUN_W'(LOCK_CNT)) ? run_cnt : run_cnt + 1'b1;

  assign diff     = $signed({1'b0, win_cnt}) - $signed({3'b000, n_q});
  assign diff_abs = diff[6] ? 7'(-diff) : 7'(diff);
  assign pass     = (diff_abs <= 7'(TOL));

  // meas_valid is a single-cycle pulse, no backpressure: meas_cnt, err and
  // locked are all valid in that same cycle and must be taken then.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      ref_cnt    <= '0;
      to_cnt     <= '0;
      run_cnt    <= '0;
      m_q        <= '0;
      n_q        <= '0;
      locked     <= 1'b0;
      meas_valid <= 1'b0;
      meas_cnt   <= '0;
      err        <= 1'b0;
      lost_ref   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;

      if (ref_rise) begin
        to_cnt   <= '0;
        lost_ref <= 1'b0;
      end else if (timeout_hit) begin
        to_cnt   <= '0;
        lost_ref <= 1'b1;
      end else if (!lost_ref) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (cfg_err) begin
        state   <= IDLE;
        locked  <= 1'b0;
        run_cnt <= '0;
      end else if (timeout_hit) begin
        state   <= IDLE;
        locked  <= 1'b0;
        run_cnt <= '0;
        err     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ref_rise) begin
              win_cnt <= CNT_W'(1);
              ref_cnt <= '0;
              m_q     <= M;
              n_q     <= N;
              state   <= MEASURE;
            end
          end
          MEASURE, CHECK: begin
            if (cfg_chg) begin
              state   <= IDLE;
              locked  <= 1'b0;
              run_cnt <= '0;
            end else if (close_win) begin
              // The closing edge cycle belongs to the next window, hence preset to 1.
              state      <= CHECK;
              meas_cnt   <= win_cnt;
              meas_valid <= 1'b1;
              win_cnt    <= CNT_W'(1);
              ref_cnt    <= '0;
              if (pass) begin
                run_cnt <= run_inc;
                locked  <= (run_inc == RUN_W'(LOCK_CNT));
              end else begin
                err     <= 1'b1;
                run_cnt <= '0;
                locked  <= 1'b0;
              end
            end else begin
              state   <= MEASURE;
              win_cnt <= win_inc;
              if (ref_rise) ref_cnt <= ref_cnt_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fmdll_lock_mon.sv
// Scoreboard bench for fmdll_lock_mon: random reference periods are fed to a
// window-level model that queues the expected result of each completed window.
module tb_fmdll_lock_mon;

  localparam int LOCK_CNT = 4;
  localparam int TOL      = 1;
  localparam int TIMEOUT  = 255;

  logic       clk_out = 1'b0;
  logic       rst     = 1'b1;
  logic       clk_ext = 1'b0;
  logic [1:0] M       = 2'd1;
  logic [3:0] N       = 4'd8;
  logic       locked;
  logic       meas_valid;
  logic [5:0] meas_cnt;
  logic       err;
  logic       lost_ref;
  logic       cfg_err;

  fmdll_lock_mon #(
    .LOCK_CNT (LOCK_CNT),
    .TOL      (TOL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_out    (clk_out),
    .rst        (rst),
    .clk_ext    (clk_ext),
    .M          (M),
    .N          (N),
    .locked     (locked),
    .meas_valid (meas_valid),
    .meas_cnt   (meas_cnt),
    .err        (err),
    .lost_ref   (lost_ref),
    .cfg_err    (cfg_err)
  );

  // clock / cycle counter
  always #5 clk_out = ~clk_out;

  int cyc = 0;
  always @(posedge clk_out) cyc <= cyc + 1;

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_item;
  int         to_exp  = 0;
  int         to_seen = 0;

  // reference model state (window level)
  int cur_m = 1;
  int cur_n = 8;
  bit m_open = 1'b0;
  int m_cnt = 0;
  int m_k = 0;
  int m_mw = 0;
  int m_nw = 0;
  int m_run = 0;
  bit m_locked = 1'b0;
  bit m_lost = 1'b0;
  int last_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic model_drop();
    m_open   = 1'b0;
    m_run    = 0;
    m_locked = 1'b0;
  endtask

  task automatic model_cfg(input int mm, input int nn);
    M     = mm[1:0];
    N     = nn[3:0];
    cur_m = mm;
    cur_n = nn;
    if (mm == 0 || nn == 0) model_drop();
    else if (m_open && (mm != m_mw || nn != m_nw)) model_drop();
  endtask

  task automatic model_rise();
    int p;
    int meas;
    int d;
    bit pass;
    p = cyc - last_rise;
    last_rise = cyc;
    m_lost = 1'b0;
    if (cur_m == 0 || cur_n == 0) return;
    if (!m_open) begin
      m_open = 1'b1;
      m_cnt  = 0;
      m_k    = 0;
      m_mw   = cur_m;
      m_nw   = cur_n;
      return;
    end
    m_cnt += p;
    m_k++;
    if (m_k == m_mw) begin
      meas = (m_cnt > 63) ? 63 : m_cnt;
      d = meas - m_nw;
      if (d < 0) d = -d;
      pass = (d <= TOL);
      if (pass) begin
        if (m_run < LOCK_CNT) m_run++;
        m_locked = (m_run >= LOCK_CNT);
      end else begin
        m_run = 0;
        m_locked = 1'b0;
      end
      exp_q.push_back({meas[5:0], ~pass, m_locked});
      m_cnt = 0;
      m_k = 0;
    end
  endtask

  // driver: one reference period (rise now, high for hi, low for lo);
  // chg_n >= 0 changes N two cycles into the low phase.
  task automatic drive_period(input int hi, input int lo, input int chg_n);
    clk_ext = 1'b1;
    model_rise();
    repeat (hi) @(negedge clk_out);
    clk_ext = 1'b0;
    if (chg_n >= 0) begin
      repeat (2) @(negedge clk_out);
      model_cfg(cur_m, chg_n);
      repeat (lo - 2) @(negedge clk_out);
    end else begin
      repeat (lo) @(negedge clk_out);
    end
    if (cyc - last_rise > TIMEOUT + 8 && !m_lost) begin
      to_exp++;
      m_lost = 1'b1;
      model_drop();
    end
    check("period_locked", 32'(locked), 32'(m_locked));
    check("period_lost_ref", 32'(lost_ref), 32'(m_lost));
    check("period_cfg_err", 32'(cfg_err), 32'(cur_m == 0 || cur_n == 0));
  endtask

  task automatic rand_period(input int p);
    int hi;
    hi = $urandom_range(2, p - 2);
    drive_period(hi, p - hi, -1);
  endtask

  task automatic pair_windows(input int cnt, input int sum);
    int p1;
    for (int i = 0; i < cnt; i++) begin
      p1 = $urandom_range(sum / 2 - 1, sum / 2 + 2);
      rand_period(p1);
      rand_period(sum - p1);
    end
  endtask

  task automatic do_reset();
    clk_ext = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_meas_cnt", 32'(meas_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_lost_ref", 32'(lost_ref), 32'd0);
    model_drop();
    m_lost = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_out);
    rst = 1'b0;
    last_rise = cyc;
  endtask

  // monitor: pops one expectation per meas_valid; bare err means timeout
  always @(negedge clk_out) begin
    if (!rst) begin
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_meas_valid actual=%0d expected=none cycle=%0d", meas_cnt, cyc);
        end else begin
          exp_item = exp_q.pop_front();
          check("meas_cnt", 32'(meas_cnt), 32'(exp_item[7:2]));
          check("window_err", 32'(err), 32'(exp_item[1]));
          check("window_locked", 32'(locked), 32'(exp_item[0]));
        end
      end else if (err) begin
        to_seen++;
        check("timeout_gap", 32'(cyc - last_rise >= TIMEOUT && cyc - last_rise <= TIMEOUT + 8), 32'd1);
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk_out);
    errors++;
    $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int mm;
    int nn;
    int r;
    model_cfg(1, 8);
    do_reset();
    check("cfg_err_valid", 32'(cfg_err), 32'd0);

    // 8x, M=1: lock on the 4th window
    for (int i = 0; i < 8; i++) rand_period(8);

    // 6.5x then 7.5x with M=2, N=12
    model_cfg(2, 12);
    rand_period(7);
    pair_windows(6, 13);
    pair_windows(2, 15);

    // lock, lose the reference for 300 cycles, relock
    model_cfg(1, 8);
    for (int i = 0; i < 6; i++) rand_period(8);
    drive_period(4, 300, -1);
    check("lost_ref_set", 32'(lost_ref), 32'd1);
    for (int i = 0; i < 6; i++) rand_period(8);

    // N 8 -> 10 mid-window, then 10x
    drive_period(3, 5, 10);
    check("abort_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 6; i++) rand_period(10);

    // M=0 for 100 reference periods, then M=1
    model_cfg(0, 10);
    @(negedge clk_out);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    for (int i = 0; i < 100; i++) rand_period(10);
    model_cfg(1, 10);
    @(negedge clk_out);
    check("cfg_err_clr", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 6; i++) rand_period(10);

    // reset in the middle of window 3
    model_cfg(2, 15);
    for (int i = 0; i < 6; i++) rand_period(8);
    do_reset();
    for (int i = 0; i < 10; i++) rand_period(8);

    // random configurations and near-matching periods
    for (int s = 0; s < 4; s++) begin
      mm = $urandom_range(1, 3);
      r  = $urandom_range(4, 15 / mm);
      nn = mm * r + $urandom_range(0, 2) - 1;
      if (nn > 15) nn = 15;
      model_cfg(mm, nn);
      for (int i = 0; i < 12; i++) rand_period(r + (($urandom_range(0, 3) == 0) ? 1 : 0));
    end

    // window counter saturation at 63
    model_cfg(3, 15);
    for (int i = 0; i < 7; i++) rand_period(22);

    repeat (10) @(negedge clk_out);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("timeout_count", 32'(to_seen), 32'(to_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmdll_lock_mon.md
FMDLL_LOCK_MON -- requirements
Module: fmdll_lock_mon

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive in-tolerance windows required to assert locked.
REQ-002 SHALL have parameter TOL, default 1: allowed absolute deviation of the measured count from N, in clk_out cycles.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum clk_out cycles allowed between reference edges.
REQ-004 SHALL have ports:
- clk_out  input  1  sole clock; the DLL output being monitored.
- rst  input  1  asynchronous, active-high reset.
- clk_ext  input  1  reference clock, sampled as data only.
- M  input  2  reference-period count per window.
- N  input  4  expected clk_out cycles per window.
- locked  output  1  DLL output frequency verified.
- meas_valid  output  1  one-cycle pulse when a window completes.
- meas_cnt  output  6  clk_out cycles counted in the last completed window.
- err  output  1  one-cycle pulse on an out-of-tolerance window or a timeout.
- lost_ref  output  1  sticky flag: no reference edge within TIMEOUT.
- cfg_err  output  1  set while M==0 or N==0.
REQ-005 SHALL use one clock and an asynchronous, active-high reset (clk_out, rst); no other clock domain is used internally.

Function
REQ-006 SHALL pass clk_ext through a 2-flop synchronizer and detect rising edges from it (ref_rise, 1 cycle), giving 3 cycles of latency from the raw edge.
REQ-007 SHALL operate with a 3-state FSM: IDLE, MEASURE, CHECK.
REQ-008 In IDLE, on ref_rise with a valid config, SHALL clear the window counter to 1 and the reference-edge counter to 0, then go to MEASURE.
REQ-009 In MEASURE, SHALL increment the window counter every cycle, saturating at 63.
REQ-010 In MEASURE, SHALL increment the reference-edge counter on each ref_rise.
REQ-011 When the reference-edge counter reaches M, SHALL go to CHECK.
REQ-012 On entering CHECK, SHALL latch meas_cnt equal to the count up to but excluding the closing ref_rise cycle, which is the number of clk_out cycles in M reference periods.
REQ-013 CHECK SHALL last 1 cycle:
- meas_valid=1.
- Pass if |meas_cnt - N| <= TOL, computed with 7-bit signed arithmetic.
- Pass: increment the run counter (saturates at LOCK_CNT); set locked=1 when it reaches LOCK_CNT.
- Fail: err=1, run counter=0, locked=0.
REQ-014 After CHECK, SHALL start the next window immediately: the closing ref_rise also opens the next window, so the window counter is preset so that no clk_out cycle is dropped or double-counted. Go to MEASURE.
REQ-015 If 0 < M, N has changed since the window opened, SHALL abort the window: go to IDLE, clear locked and the run counter, no err pulse.
REQ-016 While M==0 or N==0:
- cfg_err=1.
- FSM held in IDLE.
- locked=0.
- No meas_valid or err.
REQ-017 A timeout counter SHALL clear on every ref_rise; if it reaches TIMEOUT, SHALL:
- pulse err,
- set lost_ref,
- clear locked and the run counter,
- go to IDLE.
REQ-018 lost_ref SHALL clear only on the next ref_rise or on reset.
REQ-019 If ref_rise and a timeout occur in the same cycle, ref_rise SHALL take priority and no timeout is raised.
REQ-020 Correct measurement SHALL require each clk_ext high and low phase to span at least 2 clk_out cycles; slower clk_out is reported as a fail or timeout, never as locked.

Reset
REQ-021 While rst=1, SHALL set:
- FSM to IDLE,
- all counters to 0,
- synchronizer flops to 0,
- locked=0, meas_valid=0, meas_cnt=0, err=0, lost_ref=0.
REQ-022 cfg_err SHALL follow M and N combinationally regardless of reset.
REQ-023 When rst asserts mid-window, SHALL discard the partial window.
REQ-024 After rst deasserts, the first window SHALL open on the first synchronized ref_rise.

Structure
REQ-025 Package fmdll_pkg SHALL hold:
- the FSM state enum,
- CNT_W=6,
- the default LOCK_CNT, TOL and TIMEOUT constants.
REQ-026 The synchronizer and edge detector SHALL be a sub-module fmdll_edge_sync (ports: clk_out, rst, d, rise).
REQ-027 All remaining logic SHALL be in fmdll_lock_mon.

Verification
REQ-028 Bench SHALL cover: M=1, N=8, clk_out exactly 8x clk_ext -> meas_cnt=8 every window; locked=1 on the 4th meas_valid; err never asserts.
REQ-029 Bench SHALL cover: M=2, N=12, clk_out at 6.5x (13 per window) -> pass within TOL=1; locked after 4 windows. Then change to 7.5x (15 per window) -> err pulse and locked=0 on the next CHECK.
REQ-030 Bench SHALL cover: locked state, then clk_ext held low for 300 clk_out cycles -> err pulse and lost_ref=1 at cycle 255. Then resume clk_ext -> lost_ref clears on the first ref_rise; relock takes 4 windows.
REQ-031 Bench SHALL cover: N changed from 8 to 10 mid-window -> window aborted, locked=0, no err. Then 10x clock -> locked after 4 windows.
REQ-032 Bench SHALL cover: M=0 -> cfg_err=1, no meas_valid for 100 reference periods. Then M=1 -> normal operation.
REQ-033 Bench SHALL cover: rst pulsed in the middle of window 3 -> all outputs 0 immediately; after release, exactly 4 full windows are needed before locked=1.
